// File: rtl/uart_fifo_lite_pkg.sv
// Shared constants for the FIFO UART: register map, bit positions, response codes, FSM states.
package uart_fifo_lite_pkg;

  localparam logic [7:0] ADDR_RX      = 8'h00;
  localparam logic [7:0] ADDR_TX      = 8'h04;
  localparam logic [7:0] ADDR_STATUS  = 8'h08;
  localparam logic [7:0] ADDR_CONTROL = 8'h0C;
  localparam logic [7:0] ADDR_DIV     = 8'h10;

  localparam int ST_RXVALID  = 0;
  localparam int ST_RXFULL   = 1;
  localparam int ST_TXEMPTY  = 2;
  localparam int ST_TXFULL   = 3;
  localparam int ST_IE       = 4;
  localparam int ST_OVERRUN  = 5;
  localparam int ST_FRAMEERR = 6;
  localparam int ST_TXBUSY   = 7;

  localparam int CTL_RST_TX = 0;
  localparam int CTL_RST_RX = 1;
  localparam int CTL_IE     = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flush wins over a same-cycle push, empty pop is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so a full FIFO can take both at once.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_lite.sv
// AXI-Lite UART with TX/RX FIFOs, runtime 16x baud divisor, oversampled RX and sticky error flags.
module uart_fifo_lite
  import uart_fifo_lite_pkg::*;
#(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_awvalid_i,
  output logic        cfg_awready_o,
  input  logic [31:0] cfg_awaddr_i,
  input  logic        cfg_wvalid_i,
  output logic        cfg_wready_o,
  input  logic [31:0] cfg_wdata_i,
  input  logic [3:0]  cfg_wstrb_i,
  output logic        cfg_bvalid_o,
  input  logic        cfg_bready_i,
  output logic [1:0]  cfg_bresp_o,
  input  logic        cfg_arvalid_i,
  output logic        cfg_arready_o,
  input  logic [31:0] cfg_araddr_i,
  output logic        cfg_rvalid_o,
  input  logic        cfg_rready_i,
  output logic [31:0] cfg_rdata_o,
  output logic [1:0]  cfg_rresp_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        intr_o
);

  localparam logic [15:0] DIV_RST  = 16'(CLK_FREQ / (16 * DEFAULT_BAUD) - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic [7:0]  wr_addr, rd_addr;
  logic        wr_hs, rd_hs;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_val;
  logic        tx_push, tx_flush, rx_flush, div_wr, ctrl_wr, rx_pop, status_clr;

  logic [15:0] div, tick_cnt;
  logic        tick;
  logic        ie, overrun, frameerr;
  logic [7:0]  status;

  logic                 tx_full, tx_empty, tx_pop, tx_busy;
  logic [DATA_BITS-1:0] tx_fifo_data, tx_shift;
  tx_state_t            tx_state;
  logic [3:0]           tx_cnt;
  logic [2:0]           tx_idx;

  logic                 rx_full, rx_empty, rx_push_req, overrun_set, frame_set;
  logic [DATA_BITS-1:0] rx_fifo_data, rx_shift;
  rx_state_t            rx_state;
  logic [3:0]           rx_cnt;
  logic [2:0]           rx_idx;
  logic                 rx_meta, rx_sync, rx_prev;

  logic unused;
  assign unused = ^{cfg_awaddr_i[31:8], cfg_araddr_i[31:8], cfg_wdata_i, cfg_wstrb_i};

  assign wr_addr = cfg_awaddr_i[7:0];
  assign rd_addr = cfg_araddr_i[7:0];
  assign wr_hs   = cfg_awready_o && cfg_awvalid_i && cfg_wvalid_i;
  assign rd_hs   = cfg_arready_o && cfg_arvalid_i;

  // ---------------- AXI-Lite write path ----------------
  always_comb begin
    wr_resp  = RESP_SLVERR;
    tx_push  = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    div_wr   = 1'b0;
    ctrl_wr  = 1'b0;
    if (wr_hs && cfg_wstrb_i[0]) begin
      case (wr_addr)
        ADDR_TX: if (!tx_full) begin
          tx_push = 1'b1;
          wr_resp = RESP_OKAY;
        end
        ADDR_CONTROL: begin
          ctrl_wr  = 1'b1;
          tx_flush = cfg_wdata_i[CTL_RST_TX];
          rx_flush = cfg_wdata_i[CTL_RST_RX];
          wr_resp  = RESP_OKAY;
        end
        ADDR_DIV: begin
          div_wr  = 1'b1;
          wr_resp = RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_awready_o <= 1'b0;
      cfg_wready_o  <= 1'b0;
      cfg_bvalid_o  <= 1'b0;
      cfg_bresp_o   <= RESP_OKAY;
    end else begin
      // Ready is a one-cycle pulse; the master holds valid through it.
      cfg_awready_o <= cfg_awvalid_i && cfg_wvalid_i && !cfg_bvalid_o && !cfg_awready_o;
      cfg_wready_o  <= cfg_awvalid_i && cfg_wvalid_i && !cfg_bvalid_o && !cfg_awready_o;
      if (wr_hs) begin
        cfg_bvalid_o <= 1'b1;
        cfg_bresp_o  <= wr_resp;
      end else if (cfg_bvalid_o && cfg_bready_i) begin
        cfg_bvalid_o <= 1'b0;
      end
    end
  end

  // ---------------- AXI-Lite read path ----------------
  always_comb begin
    status              = '0;
    status[ST_RXVALID]  = !rx_empty;
    status[ST_RXFULL]   = rx_full;
    status[ST_TXEMPTY]  = tx_empty;
    status[ST_TXFULL]   = tx_full;
    status[ST_IE]       = ie;
    status[ST_OVERRUN]  = overrun;
    status[ST_FRAMEERR] = frameerr;
    status[ST_TXBUSY]   = tx_busy;
  end

  always_comb begin
    rd_val     = '0;
    rd_resp    = RESP_OKAY;
    rx_pop     = 1'b0;
    status_clr = 1'b0;
    case (rd_addr)
      ADDR_RX: if (!rx_empty) begin
        rd_val[DATA_BITS-1:0] = rx_fifo_data;
        rx_pop                = rd_hs;
      end
      ADDR_STATUS: begin
        rd_val[7:0] = status;
        status_clr  = rd_hs;
      end
      ADDR_CONTROL: rd_val[CTL_IE] = ie;
      ADDR_DIV:     rd_val[15:0]   = div;
      default:      rd_resp        = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_arready_o <= 1'b0;
      cfg_rvalid_o  <= 1'b0;
      cfg_rdata_o   <= '0;
      cfg_rresp_o   <= RESP_OKAY;
    end else begin
      cfg_arready_o <= cfg_arvalid_i && !cfg_rvalid_o && !cfg_arready_o;
      if (rd_hs) begin
        cfg_rvalid_o <= 1'b1;
        cfg_rdata_o  <= rd_val;
        cfg_rresp_o  <= rd_resp;
      end else if (cfg_rvalid_o && cfg_rready_i) begin
        cfg_rvalid_o <= 1'b0;
      end
    end
  end

  // ---------------- Baud tick, control and flags ----------------
  assign tick = (tick_cnt == div);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div      <= DIV_RST;
      tick_cnt <= '0;
    end else if (div_wr) begin
      div      <= cfg_wdata_i[15:0];
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
    end
  end

  assign overrun_set = rx_push_req && rx_full && !rx_pop;
  assign frame_set   = (rx_state == RX_STOP) && tick && (rx_cnt == 4'd15) && !rx_sync;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ie       <= 1'b0;
      overrun  <= 1'b0;
      frameerr <= 1'b0;
      intr_o   <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= cfg_wdata_i[CTL_IE];
      overrun  <= overrun_set || (overrun && !status_clr);
      frameerr <= frame_set || (frameerr && !status_clr);
      intr_o   <= ie && (!rx_empty || overrun || frameerr || (tx_empty && !tx_busy));
    end
  end

  // ---------------- TX ----------------
  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (tx_flush),
    .push  (tx_push),
    .wdata (cfg_wdata_i[DATA_BITS-1:0]),
    .pop   (tx_pop),
    .rdata (tx_fifo_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_o     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_shift <= tx_fifo_data;
          tx_o     <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= TX_START;
        end
        TX_START: if (tick) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            tx_o     <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: if (tick) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            if (tx_idx == LAST_BIT) begin
              tx_o     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_o     <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + 3'd1;
            end
          end
        end
        TX_STOP: if (tick) begin
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  assign rx_push_req = (rx_state == RX_STOP) && tick && (rx_cnt == 4'd15) && rx_sync;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (rx_flush),
    .push  (rx_push_req),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .rdata (rx_fifo_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        // Half a bit into the start bit: still low is a real frame, high was a glitch.
        RX_START: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd7) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == LAST_BIT) rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_lite.sv
// Directed bench for uart_fifo_lite: register access, TX framing, RX, FIFO limits, errors, handshakes.
module tb_uart_fifo_lite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        rx, tx, intr;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo_lite dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_awvalid_i(awvalid), .cfg_awready_o(awready), .cfg_awaddr_i(awaddr),
    .cfg_wvalid_i(wvalid), .cfg_wready_o(wready), .cfg_wdata_i(wdata), .cfg_wstrb_i(wstrb),
    .cfg_bvalid_o(bvalid), .cfg_bready_i(bready), .cfg_bresp_o(bresp),
    .cfg_arvalid_i(arvalid), .cfg_arready_o(arready), .cfg_araddr_i(araddr),
    .cfg_rvalid_o(rvalid), .cfg_rready_i(rready), .cfg_rdata_o(rdata), .cfg_rresp_o(rresp),
    .rx_i(rx), .tx_o(tx), .intr_o(intr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = {24'h0, a}; wdata = d; wstrb = s;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    resp = (n < 50) ? bresp : 2'b11;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = {24'h0, a};
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    d    = (n < 50) ? rdata : 32'hDEAD_DEAD;
    resp = (n < 50) ? rresp : 2'b11;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0; repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (64) @(negedge clk); end
    rx = stop; repeat (64) @(negedge clk);
    rx = 1'b1; repeat (16) @(negedge clk);
  endtask

  task automatic wait_tx_fall(output int at);
    int n = 0;
    while (tx === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    at = cyc;
    chk("tx_start_seen", 32'(tx), 32'h0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  a5;
    int          fall, okays, acc, stable;

    rst_n = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_valids", 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
    chk("rst_intr", 32'(intr), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    axi_read(8'h08, d, r); chk("rst_status", d, 32'h04); chk("rst_status_resp", 32'(r), 32'h0);
    axi_read(8'h10, d, r); chk("rst_div", d, 32'd66);

    axi_write(8'h10, 32'd3, 4'hF, r); chk("div_wr_resp", 32'(r), 32'h0);
    axi_read(8'h10, d, r); chk("div_rd", d, 32'd3);
    axi_write(8'h10, 32'd7, 4'hE, r); chk("nostrb_resp", 32'(r), 32'h2);
    axi_read(8'h10, d, r); chk("nostrb_div_kept", d, 32'd3);
    axi_read(8'h04, d, r); chk("rd_tx_resp", 32'(r), 32'h2); chk("rd_tx_data", d, 32'h0);
    axi_write(8'h08, 32'h1, 4'hF, r); chk("wr_status_resp", 32'(r), 32'h2);
    axi_read(8'h20, d, r); chk("rd_bad_resp", 32'(r), 32'h2);
    axi_read(8'h00, d, r); chk("rx_empty_data", d, 32'h0); chk("rx_empty_resp", 32'(r), 32'h0);

    // TX frame 0xA5, sampled mid-bit
    axi_write(8'h04, 32'hA5, 4'h1, r); chk("tx_wr_resp", 32'(r), 32'h0);
    wait_tx_fall(fall);
    axi_read(8'h08, d, r); chk("tx_busy_status", d, 32'h84);
    wait_cyc(fall + 32); chk("tx_start_bit", 32'(tx), 32'h0);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(fall + 96 + 64 * i);
      chk($sformatf("tx_bit%0d", i), 32'(tx), 32'(a5[i]));
    end
    wait_cyc(fall + 96 + 64 * 8); chk("tx_stop_bit", 32'(tx), 32'h1);
    wait_cyc(fall + 720);
    axi_read(8'h08, d, r); chk("tx_done_status", d, 32'h04);

    // Fill TX FIFO: one byte goes in flight, 16 more fill it, the next is refused
    okays = 0;
    for (int i = 0; i < 17; i++) begin
      axi_write(8'h04, 32'(i), 4'h1, r);
      if (r == 2'b00) okays++;
    end
    chk("tx_fill_okays", 32'(okays), 32'd17);
    axi_read(8'h08, d, r); chk("tx_full_status", d, 32'h88);
    axi_write(8'h04, 32'h55, 4'h1, r); chk("tx_full_slverr", 32'(r), 32'h2);
    axi_write(8'h0C, 32'h1, 4'h1, r); chk("tx_flush_resp", 32'(r), 32'h0);
    axi_read(8'h08, d, r); chk("tx_flush_status", d, 32'h84);
    repeat (700) @(negedge clk);
    axi_read(8'h08, d, r); chk("tx_flush_idle", d, 32'h04);

    // RX single frame
    send_frame(8'h3C, 1'b1);
    axi_read(8'h08, d, r); chk("rx_valid_status", d, 32'h05);
    axi_read(8'h00, d, r); chk("rx_data", d, 32'h3C);
    axi_read(8'h08, d, r); chk("rx_popped_status", d, 32'h04);

    // Overrun
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
    axi_read(8'h08, d, r); chk("overrun_status", d, 32'h27);
    axi_read(8'h08, d, r); chk("overrun_cleared", d, 32'h07);
    for (int i = 0; i < 16; i++) begin
      axi_read(8'h00, d, r);
      chk($sformatf("rx_fifo_byte%0d", i), d, 32'h10 + 32'(i));
    end
    axi_read(8'h08, d, r); chk("rx_drained", d, 32'h04);

    // Framing error and interrupt
    send_frame(8'h55, 1'b0);
    chk("intr_ie_off", 32'(intr), 32'h0);
    axi_write(8'h0C, 32'h10, 4'h1, r);
    repeat (2) @(negedge clk);
    chk("intr_ie_on", 32'(intr), 32'h1);
    axi_read(8'h08, d, r); chk("frameerr_status", d, 32'h54);
    axi_read(8'h08, d, r); chk("frameerr_cleared", d, 32'h14);
    axi_read(8'h0C, d, r); chk("control_rd", d, 32'h10);
    axi_write(8'h0C, 32'h0, 4'h1, r);
    repeat (2) @(negedge clk);
    chk("intr_off_again", 32'(intr), 32'h0);

    // Short glitch must not start a frame
    rx = 1'b0; repeat (6) @(negedge clk); rx = 1'b1;
    repeat (700) @(negedge clk);
    axi_read(8'h08, d, r); chk("glitch_status", d, 32'h04);

    // Back-pressure on B: response held, no second accept
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h10; wdata = 32'd3; wstrb = 4'hF;
    acc = 0;
    while (!awready && acc < 50) begin @(negedge clk); acc++; end
    @(negedge clk);
    acc = 0; stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (awready) acc++;
      if (bvalid && bresp == 2'b00) stable++;
    end
    chk("b_held", 32'(stable), 32'd5);
    chk("b_no_second_accept", 32'(acc), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    chk("b_released", 32'(bvalid), 32'h0);

    // Back-pressure on R
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h10;
    acc = 0;
    while (!arready && acc < 50) begin @(negedge clk); acc++; end
    @(negedge clk);
    acc = 0; stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (arready) acc++;
      if (rvalid && rdata == 32'd3 && rresp == 2'b00) stable++;
    end
    chk("r_held", 32'(stable), 32'd5);
    chk("r_no_second_accept", 32'(acc), 32'd0);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk); rready = 1'b0;
    chk("r_released", 32'(rvalid), 32'h0);

    // Mid-frame reset returns the line to idle
    axi_write(8'h04, 32'h00, 4'h1, r);
    wait_tx_fall(fall);
    repeat (100) @(negedge clk);
    chk("tx_mid_low", 32'(tx), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("tx_mid_reset", 32'(tx), 32'h1);
    rst_n = 1'b1;
    axi_read(8'h10, d, r); chk("div_after_reset", d, 32'd66);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
